run_dump_controller: RTL and testbench

Run-control and memory-dump unit that sits beside the single-cycle core and its data memory. It counts execution cycles, detects program halt by watching the program counter (PC) stop changing, or stops the core on a cycle-budget timeout. It then freezes the core and streams every data-memory word out over a valid/ready port. This replaces fixed-duration simulation runs with a defined end-of-program condition and gives an in-hardware memory readout.

---
 rtl/run_dump_controller.sv | 114 +++++++++++
 tb/tb_run_dump_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_dump_controller.sv
// Run-control and data-memory dump unit: counts RUN cycles, detects halt from a
// stationary PC or a cycle-budget timeout, then stalls the core and streams memory out.
module run_dump_controller #(
  parameter int DATA_WIDTH     = 20,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int MEM_SIZE       = 256,
  parameter int HALT_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     core_stall,
  output logic                     mem_rd_en,
  output logic [ADDRESS_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rd_data,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [DATA_WIDTH-1:0]    dump_data,
  output logic [ADDRESS_WIDTH-1:0] dump_addr,
  output logic                     dump_last,
  output logic                     done,
  output logic                     timed_out,
  output logic [CNT_WIDTH-1:0]     cycle_count
);

  localparam int unsigned STABLE_W = $clog2(HALT_CYCLES + 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR    = ADDRESS_WIDTH'(MEM_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]     TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [STABLE_W-1:0]      HALT_LAST    = STABLE_W'(HALT_CYCLES - 1);
  localparam logic [STABLE_W-1:0]      HALT_MAX     = STABLE_W'(HALT_CYCLES);

  typedef enum logic [2:0] {RUN, FETCH, CAPTURE, SEND, DONE} state_t;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pc_prev;
  logic [ADDRESS_WIDTH-1:0] addr_cnt;
  logic                     prev_valid;
  logic [STABLE_W-1:0]      stable_cnt;
  logic                     same, halt_hit, timeout_hit, accept;

  assign same        = prev_valid && (pc == pc_prev);
  assign halt_hit    = same && (stable_cnt == HALT_LAST);
  assign timeout_hit = (cycle_count == TIMEOUT_LAST);
  assign accept      = (state == SEND) && dump_valid && dump_ready;
  assign dump_last   = dump_valid && (dump_addr == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (halt_hit || timeout_hit) state_nxt = FETCH;
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (accept) state_nxt = (addr_cnt == LAST_ADDR) ? DONE : FETCH;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    done        = 1'b0;
    if (state == FETCH) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = addr_cnt;
    end
    if (state == DONE) done = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_stall  <= 1'b0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
      pc_prev     <= '0;
      prev_valid  <= 1'b0;
      stable_cnt  <= '0;
      addr_cnt    <= '0;
      dump_valid  <= 1'b0;
      dump_data   <= '0;
      dump_addr   <= '0;
    end else begin
      if (state == RUN) begin
        if (cycle_count != '1) cycle_count <= cycle_count + CNT_WIDTH'(1);
        prev_valid <= 1'b1;
        pc_prev    <= pc;
        if (!same)                     stable_cnt <= '0;
        else if (stable_cnt != HALT_MAX) stable_cnt <= stable_cnt + STABLE_W'(1);
        // Halt takes priority, so timed_out only marks a pure timeout.
        if (halt_hit || timeout_hit) begin
          core_stall <= 1'b1;
          timed_out  <= !halt_hit;
        end
      end
      if (state == CAPTURE) begin
        dump_data  <= mem_rd_data;
        dump_addr  <= addr_cnt;
        dump_valid <= 1'b1;
      end
      if (accept) begin
        dump_valid <= 1'b0;
        if (addr_cnt != LAST_ADDR) addr_cnt <= addr_cnt + ADDRESS_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_run_dump_controller.sv
// Directed bench for run_dump_controller: table-driven halt/glitch vectors plus
// sequences for full dumps, backpressure, timeout, coincident events and mid-dump reset.
module tb_run_dump_controller;

  localparam int MEM = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pc = '0;
  logic        core_stall, mem_rd_en, dump_valid, dump_last, done, timed_out;
  logic        dump_ready = 1'b0;
  logic [7:0]  mem_rd_addr, dump_addr;
  logic [19:0] mem_rd_data = '0;
  logic [19:0] dump_data;
  logic [31:0] cycle_count;
  logic [19:0] mem [MEM];

  int checks = 0;
  int errors = 0;

  run_dump_controller #(
    .DATA_WIDTH(20), .ADDRESS_WIDTH(8), .MEM_SIZE(MEM),
    .HALT_CYCLES(4), .TIMEOUT_CYCLES(50), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .core_stall(core_stall),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_addr(dump_addr), .dump_last(dump_last), .done(done),
    .timed_out(timed_out), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory, one-cycle latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct {
    bit          new_run;
    logic [7:0]  pc;
    logic        stall;
    logic [2:0]  stable;
    logic [31:0] cnt;
  } vec_t;
  vec_t vecs[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ctrl", {core_stall, mem_rd_en, dump_valid, dump_last, done, timed_out}, 0);
    chk("rst_data", {dump_data, dump_addr, mem_rd_addr}, 0);
    chk("rst_cnt", cycle_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].new_run) do_reset();
      pc = vecs[i].pc;
      step();
      chk($sformatf("vec%0d_stall", i), core_stall, vecs[i].stall);
      chk($sformatf("vec%0d_stable", i), dut.stable_cnt, vecs[i].stable);
      chk($sformatf("vec%0d_cnt", i), cycle_count, vecs[i].cnt);
    end
  endtask

  task automatic wait_stall(input int budget);
    for (int n = 0; n < budget && !core_stall; n++) step();
    chk("stall_within_budget", core_stall, 1);
  endtask

  // Called at the sample point right after the edge that entered FETCH.
  task automatic run_dump(input bit bp, input int exp_cycles, input bit exp_to);
    int e = 0;
    int n = 0;
    int vcnt = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [19:0] pd = '0;
    logic [7:0]  pa = '0;
    while (!done && n < 4000) begin
      if (pv && !pr) chk("valid_held", dump_valid, 1);
      chk("no_read_while_pending", mem_rd_en & dump_valid, 0);
      if (dump_valid) begin
        if (!(pv && !pr)) begin
          chk("dump_addr", dump_addr, e);
          chk("dump_data", dump_data, 64'h0A000 + e);
          chk("dump_last", dump_last, (e == MEM - 1));
          if (!bp) chk("dump_spacing", n, 3 * e + 2);
        end else begin
          chk("hold_stable", {dump_data, dump_addr}, {pd, pa});
        end
        vcnt++;
        dump_ready = bp ? (vcnt == 3) : 1'b1;
      end else begin
        vcnt = 0;
        dump_ready = !bp;
      end
      if (dump_valid && dump_ready) e++;
      pv = dump_valid; pr = dump_ready; pd = dump_data; pa = dump_addr;
      step();
      n++;
    end
    chk("dump_words", e, MEM);
    chk("dump_cycles", n, exp_cycles);
    chk("done", done, 1);
    chk("timed_out", timed_out, exp_to);
    chk("stall_in_done", core_stall, 1);
    chk("valid_in_done", {dump_valid, mem_rd_en}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEM; i++) mem[i] = 20'h0A000 + 20'(i);

    // Halt: PC 0,1,2,3 then held; four equal compares on cycles 4..7.
    vecs[0]  = '{1'b1, 8'd0, 1'b0, 3'd0, 32'd1};
    vecs[1]  = '{1'b0, 8'd1, 1'b0, 3'd0, 32'd2};
    vecs[2]  = '{1'b0, 8'd2, 1'b0, 3'd0, 32'd3};
    vecs[3]  = '{1'b0, 8'd3, 1'b0, 3'd0, 32'd4};
    vecs[4]  = '{1'b0, 8'd3, 1'b0, 3'd1, 32'd5};
    vecs[5]  = '{1'b0, 8'd3, 1'b0, 3'd2, 32'd6};
    vecs[6]  = '{1'b0, 8'd3, 1'b0, 3'd3, 32'd7};
    vecs[7]  = '{1'b0, 8'd3, 1'b1, 3'd4, 32'd8};
    // Glitch: PC changes on the would-be halt cycle, then four new compares.
    vecs[8]  = '{1'b1, 8'd7, 1'b0, 3'd0, 32'd1};
    vecs[9]  = '{1'b0, 8'd7, 1'b0, 3'd1, 32'd2};
    vecs[10] = '{1'b0, 8'd7, 1'b0, 3'd2, 32'd3};
    vecs[11] = '{1'b0, 8'd7, 1'b0, 3'd3, 32'd4};
    vecs[12] = '{1'b0, 8'd9, 1'b0, 3'd0, 32'd5};
    vecs[13] = '{1'b0, 8'd9, 1'b0, 3'd1, 32'd6};
    vecs[14] = '{1'b0, 8'd9, 1'b0, 3'd2, 32'd7};
    vecs[15] = '{1'b0, 8'd9, 1'b0, 3'd3, 32'd8};
    vecs[16] = '{1'b0, 8'd9, 1'b1, 3'd4, 32'd9};

    // Halt detection and full dump with the sink always ready.
    apply_vecs(0, 7);
    chk("first_read", {mem_rd_en, mem_rd_addr}, {1'b1, 8'h00});
    run_dump(1'b0, 3 * MEM, 1'b0);
    chk("halt_cnt_frozen", cycle_count, 8);

    // PC glitch.
    apply_vecs(8, 16);
    chk("glitch_timed_out", timed_out, 0);

    // Backpressure: ready low for two valid cycles, high on the third.
    do_reset();
    pc = 8'd5;
    wait_stall(20);
    chk("bp_halt_cnt", cycle_count, 5);
    run_dump(1'b1, 5 * MEM, 1'b0);

    // Timeout with the PC moving every cycle.
    do_reset();
    dump_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      pc = 8'(i);
      step();
      chk($sformatf("to_stall_c%0d", i), core_stall, (i == 49));
    end
    chk("to_flag", timed_out, 1);
    chk("to_cnt", cycle_count, 50);
    chk("to_first_read", mem_rd_en, 1);
    run_dump(1'b0, 3 * MEM, 1'b1);
    chk("to_cnt_frozen", cycle_count, 50);

    // Halt and timeout on the same cycle (cycle 49): halt wins.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      pc = (i <= 45) ? 8'(i) : 8'd45;
      step();
      if (i == 48) chk("sim_no_early_stall", core_stall, 0);
    end
    chk("sim_stall", core_stall, 1);
    chk("sim_timed_out", timed_out, 0);
    chk("sim_cnt", cycle_count, 50);

    // Reset while word 17 is pending in SEND.
    do_reset();
    pc = 8'd3;
    wait_stall(20);
    chk("md_halt_cnt", cycle_count, 5);
    dump_ready = 1'b1;
    for (int n = 0; n < 200 && !(dump_valid && dump_addr == 8'd17); n++) step();
    chk("md_reach17", {dump_valid, dump_addr}, {1'b1, 8'd17});
    rst = 1'b1;
    #1;
    chk("md_async_ctrl", {core_stall, dump_valid, done, mem_rd_en}, 0);
    chk("md_async_cnt", cycle_count, 0);
    chk("md_async_addr", dump_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("md_after_rel", {core_stall, dump_valid, done}, 0);
    chk("md_cnt_zero", cycle_count, 0);
    wait_stall(20);
    chk("md_rehalt_cnt", cycle_count, 5);
    run_dump(1'b0, 3 * MEM, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
